inst_buf_decode: RTL



---
 rtl/inst_buf_decode.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/inst_buf_decode.sv
// Decoded-instruction buffer between decode and rename: a circular FIFO that accepts up to
// four packets per cycle and hands rename four at a time. Define INSTBUF_STATS_EN to add a stall-cycle counter.
`ifndef SIZE_SPECIAL_REG
`define SIZE_SPECIAL_REG 32
`endif
`ifndef LDST_TYPES_LOG
`define LDST_TYPES_LOG 2
`endif
`ifndef INST_TYPES_LOG
`define INST_TYPES_LOG 2
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_RMT_LOG
`define SIZE_RMT_LOG 5
`endif
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 2
`endif
`ifndef BRANCH_COUNT
`define BRANCH_COUNT 3
`endif

module inst_buf_decode #(
  parameter int DEPTH = 16,
  parameter int PKT_W = 2*`SIZE_SPECIAL_REG+4+`LDST_TYPES_LOG+`INST_TYPES_LOG+`SIZE_IMMEDIATE+1+
                        3*`SIZE_RMT_LOG+3+`SIZE_OPCODE_I+2*`SIZE_PC+`SIZE_CTI_LOG
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       stall_i,
  input  logic                       decodeReady_i,
  input  logic [2:0]                 decodedCount_i,
  input  logic [PKT_W-1:0]           decodedPacket0_i,
  input  logic [PKT_W-1:0]           decodedPacket1_i,
  input  logic [PKT_W-1:0]           decodedPacket2_i,
  input  logic [PKT_W-1:0]           decodedPacket3_i,
  input  logic [3:0]                 isBranch_i,
  output logic                       instBufferFull_o,
  output logic                       instBufferReady_o,
  output logic [PKT_W-1:0]           decodedPacket0_o,
  output logic [PKT_W-1:0]           decodedPacket1_o,
  output logic [PKT_W-1:0]           decodedPacket2_o,
  output logic [PKT_W-1:0]           decodedPacket3_o,
  output logic [`BRANCH_COUNT-1:0]   branchCount_o,
`ifdef INSTBUF_STATS_EN
  output logic [31:0]                stallCycles_o,
`endif
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int BC_W  = `BRANCH_COUNT;

  logic [PTR_W-1:0] head, tail;
  logic [OCC_W-1:0] occupancy, occ_next;
  logic [PKT_W-1:0] pkt_mem [DEPTH];
  logic [DEPTH-1:0] br_mem;
  logic [PKT_W-1:0] pkt_in [4];
  logic [PTR_W-1:0] rd_idx [4];
  logic [2:0]       enq_count;
  logic [BC_W-1:0]  br_sum;
  logic             enq, deq;

  assign pkt_in[0] = decodedPacket0_i;
  assign pkt_in[1] = decodedPacket1_i;
  assign pkt_in[2] = decodedPacket2_i;
  assign pkt_in[3] = decodedPacket3_i;

  // Out-of-range counts are clamped so occupancy can never pass DEPTH.
  assign enq_count = (decodedCount_i > 3'd4) ? 3'd4 : decodedCount_i;

  assign instBufferFull_o  = occupancy > OCC_W'(DEPTH - 4);
  assign instBufferReady_o = occupancy >= OCC_W'(4);
  assign enq = decodeReady_i && !instBufferFull_o;
  assign deq = instBufferReady_o && !stall_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    occ_next = occupancy;
    if (enq) occ_next = occ_next + OCC_W'(enq_count);
    if (deq) occ_next = occ_next - OCC_W'(4);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (flush_i) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(enq_count);
      if (deq) head <= head + PTR_W'(4);
      occupancy <= occ_next;
    end
  end

  // NOTE: entry storage has no reset; validity is tracked by head/tail/occupancy alone.
  always_ff @(posedge clk) begin
    if (enq && !flush_i) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < enq_count) begin
          pkt_mem[tail + PTR_W'(k)] <= pkt_in[k];
          br_mem[tail + PTR_W'(k)]  <= isBranch_i[k];
        end
      end
    end
  end

  always_comb begin
    br_sum = '0;
    for (int n = 0; n < 4; n++) begin
      rd_idx[n] = head + PTR_W'(n);
      br_sum    = br_sum + BC_W'(br_mem[rd_idx[n]]);
    end
  end

  assign decodedPacket0_o = pkt_mem[rd_idx[0]];
  assign decodedPacket1_o = pkt_mem[rd_idx[1]];
  assign decodedPacket2_o = pkt_mem[rd_idx[2]];
  assign decodedPacket3_o = pkt_mem[rd_idx[3]];
  // Gated so stale or never-written entries cannot leak a count when no group is valid.
  assign branchCount_o    = instBufferReady_o ? br_sum : '0;
  assign occupancy_o      = occupancy;

`ifdef INSTBUF_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCycles_o <= '0;
    end else if (flush_i) begin
      stallCycles_o <= '0;
    end else if (instBufferReady_o && stall_i && (stallCycles_o != 32'hFFFF_FFFF)) begin
      stallCycles_o <= stallCycles_o + 32'd1;
    end
  end
`endif

endmodule
